fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller that consumes the PC register's current value and drives the PC's advance enable (steve). It sits between the PC register and instruction memory. It issues a read request to a variable-latency instruction memory, holds the returned word for the decode/execute side, and pulses steve once per consumed instruction so the PC steps (PC+4 or branch target, chosen by nPC_sel elsewhere).

Parameters:
TIMEOUT, 256, cycles in REQ without imem_ack before flagging err; 0 disables the timeout.
CNT_W, 9, width of the internal timeout counter; must hold TIMEOUT.

Ports:
clk  input  1  clock; all state in this block updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
pc_in  input  32  current PC, driven from the PC register's pc_fin.
imem_req  output  1  read request to instruction memory.
imem_addr  output  32  registered fetch address; stable while imem_req=1.
imem_ack  input  1  memory response valid; sampled on posedge only while imem_req=1.
imem_rdata  input  32  instruction word; valid when imem_ack=1.
inst_valid  output  1  inst/inst_pc hold a fetched, unconsumed instruction.
inst  output  32  fetched instruction word.
inst_pc  output  32  address the instruction came from.
inst_ready  input  1  downstream consumes inst when inst_valid=1 && inst_ready=1.
steve  output  1  PC advance enable; one-cycle pulse per consumed instruction.
err  output  1  sticky fetch-timeout flag.
fetch_count  output  32  number of instructions consumed.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - All outputs reset to 0: imem_req, imem_addr, inst_valid, inst, inst_pc, steve, err, fetch_count.
  - Timeout counter resets to 0.
- Reset mid-operation abandons any outstanding request. An imem_ack arriving afterwards is ignored.
- FSM states are IDLE, REQ, VALID, ADV, ERR. All outputs are registered.
- IDLE: on the next posedge, latch imem_addr<=pc_in and set imem_req<=1. Go to REQ.
- REQ: imem_req stays 1 and imem_addr is held; the request is never withdrawn.
  - On posedge with imem_ack=1: inst<=imem_rdata, inst_pc<=imem_addr, imem_req<=0, inst_valid<=1, clear the timeout counter. Go to VALID.
  - Minimum fetch latency is ack on the first posedge after req rises, giving inst_valid one cycle later.
  - Otherwise the timeout counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: imem_req<=0, err<=1. Go to ERR.
- VALID: inst_valid=1, and inst/inst_pc are stable.
  - On posedge with inst_ready=1: inst_valid<=0, steve<=1, fetch_count<=fetch_count+1 (mod 2^32, wraps to 0). Go to ADV.
  - If inst_ready=0, hold indefinitely.
- ADV: steve is high for exactly this one cycle. The PC register samples steve on the negedge inside this cycle, so pc_in holds the new PC by the next posedge.
  - On the next posedge: steve<=0, imem_addr<=pc_in, imem_req<=1. Go to REQ.
  - Throughput bound: with zero-wait memory and inst_ready tied high, one instruction per 3 cycles.
- ERR: terminal. imem_req=0, inst_valid=0, steve=0, err=1. Exit only via rst_n.
- imem_ack while not in REQ is ignored and has no state effect.
- inst_ready while inst_valid=0 is ignored.
- steve is never high in two consecutive cycles. steve is never high while imem_req=1.
- Branches: no squash logic here. The PC register selects the branch target from nPC_sel when steve pulses. The execute stage must present nPC_sel before the steve negedge, i.e. in the VALID→ADV handoff cycle.

Test Plan:
- Reset/boot: hold rst_n=0 with pc_in=0x00400020, release; memory acks after 2 cycles with 0x20080005 → imem_req rises 1 cycle after release with imem_addr=0x00400020; inst=0x20080005, inst_pc=0x00400020, inst_valid=1; all outputs were 0 during reset.
- Sequential stream, ack latency 0, inst_ready=1: PC model steps +4 on steve → addresses 0x00400020, 0x00400024, 0x00400028; steve pulses exactly 1 cycle each, 3 cycles apart; fetch_count=3.
- Backpressure: inst_ready=0 for 10 cycles in VALID → inst/inst_pc constant, steve=0, no new imem_req; raise inst_ready → single steve pulse, next imem_addr=0x00400024.
- Branch: at 0x00400028 with nPC_sel=1, imm16=0x0004 → next imem_addr equals the PC model's target; inst_pc of the following instruction matches.
- Timeout: TIMEOUT=8, never ack → imem_req drops and err=1 after 8 cycles in REQ; a late ack is ignored; err stays 1 until rst_n.
- Async reset mid-REQ and fetch_count wrap: assert rst_n=0 between edges during REQ → outputs clear immediately. Preload fetch_count=0xFFFFFFFF via force, consume one instruction → fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller sitting between the PC register and a
// variable-latency instruction memory. Each fetch latches the current PC,
// holds a read request until the memory acknowledges, presents the returned
// word downstream, and after it is consumed pulses steve for one cycle so the
// PC register steps (PC+4 or branch target, selected outside this block).
//
// A request left unanswered for TIMEOUT cycles parks the controller in a
// terminal error state; only rst_n leaves it.
//
// Parameters
//   TIMEOUT     cycles in REQ without imem_ack before err is raised (0 = never)
//   CNT_W       width of the timeout counter; must be able to hold TIMEOUT
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   pc_in        current PC from the PC register
//   imem_req     read request to instruction memory
//   imem_addr    fetch address, stable while imem_req=1
//   imem_ack     memory response valid, sampled only while in REQ
//   imem_rdata   instruction word, valid with imem_ack
//   inst_valid   inst/inst_pc hold an unconsumed instruction
//   inst         fetched instruction word
//   inst_pc      address the instruction was fetched from
//   inst_ready   downstream consumes inst when inst_valid && inst_ready
//   steve        one-cycle PC advance pulse per consumed instruction
//   err          sticky fetch-timeout flag
//   fetch_count  number of instructions consumed (wraps mod 2^32)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        steve,
    output logic        err,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_VALID = 3'd2,
        S_ADV   = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // Last counter value tolerated in REQ; the fetch gives up when the counter
    // sits here and the memory still has not answered.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e           state_q,   state_d;
    logic             req_q,     req_d;
    logic [31:0]      addr_q,    addr_d;
    logic             valid_q,   valid_d;
    logic [31:0]      inst_q,    inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic             steve_q,   steve_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      count_q,   count_d;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state signal starts from its held value so that no
        // branch below can leave one unassigned and infer a latch.
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        steve_d   = steve_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                addr_d  = pc_in;
                req_d   = 1'b1;
                state_d = S_REQ;
            end

            // The request is never withdrawn while waiting; only an ack or
            // the timeout ends it.
            S_REQ: begin
                if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = addr_q;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_VALID;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_VALID: begin
                if (inst_ready) begin
                    valid_d = 1'b0;
                    steve_d = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = S_ADV;
                end
            end

            // steve is high throughout this cycle; the PC register steps on
            // the negedge inside it, so pc_in already holds the next PC here.
            S_ADV: begin
                steve_d = 1'b0;
                addr_d  = pc_in;
                req_d   = 1'b1;
                state_d = S_REQ;
            end

            // Terminal until reset; every output keeps its parked value.
            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            steve_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            steve_q   <= steve_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign steve       = steve_q;
    assign err         = err_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Bench for fetch_ctrl. A negedge-driven environment models the PC register
// (steps on steve, +4 or branch target) and a variable-latency instruction
// memory. When the memory answers, the expected {pc, word} pair is derived
// from the PC model and pushed to a scoreboard queue; tests pop it when the
// DUT presents the instruction. DUT outputs are sampled on negedges.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        steve;
    logic        err;
    logic [31:0] fetch_count;

    // Environment controls, written only by the test sequence.
    logic [31:0] pc_boot   = 32'h0040_0020;
    int          mem_lat   = 0;
    bit          mem_en    = 1'b1;
    bit          force_ack = 1'b0;
    bit          npc_sel   = 1'b0;
    logic [15:0] imm16     = 16'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx = 0;
    int   wcnt   = 0;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .steve       (steve),
        .err         (err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: 0x00400020 holds 0x20080005.
    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'h2048_0025;
    endfunction

    // PC register + instruction memory model.
    always @(negedge clk) begin
        if (!rst_n) begin
            pc_in    = pc_boot;
            imem_ack = 1'b0;
            wcnt     = 0;
        end else begin
            if (steve)
                pc_in = npc_sel ? pc_in + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00}
                                : pc_in + 32'd4;
            imem_ack = 1'b0;
            if (!mem_en) begin
                imem_ack = force_ack;
            end else if (imem_req) begin
                if (wcnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_for(imem_addr);
                    exp_q.push_back({pc_in, word_for(pc_in)});
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic pop_exp(output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '0;
        if (rd_idx < exp_q.size()) begin
            e  = exp_q[rd_idx];
            rd_idx++;
            ok = 1'b1;
        end
    endtask

    // Waits (bounded) for inst_valid, then pops the matching expectation.
    task automatic next_inst(input int bound, output bit ok, output exp_t e);
        int n;
        n  = 0;
        ok = 1'b0;
        e  = '0;
        while (!inst_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (inst_valid) pop_exp(ok, e);
    endtask

    task automatic wait_steve(input int bound, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            @(negedge clk);
            n++;
            if (steve) ok = 1'b1;
        end
    endtask

    task automatic do_reset(input logic [31:0] pc);
        @(negedge clk);
        rst_n      = 1'b0;
        pc_boot    = pc;
        inst_ready = 1'b0;
        npc_sel    = 1'b0;
        repeat (2) @(negedge clk);
        rd_idx = exp_q.size();
        rst_n  = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        bit   ok;
        exp_t e;
        rst_n = 1'b0; pc_boot = 32'h0040_0020; mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({imem_req, inst_valid, steve, err} !== 4'b0 || imem_addr !== 32'h0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || fetch_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b valid=%b steve=%b err=%b addr=%h inst=%h inst_pc=%h count=%h, want all 0",
                     imem_req, inst_valid, steve, err, imem_addr, inst, inst_pc, fetch_count);
        end
        rd_idx = exp_q.size();
        rst_n  = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0020) begin
            bad++;
            $display("FAIL boot_req: req=%b addr=%h, want 1 00400020", imem_req, imem_addr);
        end
        next_inst(20, ok, e);
        total++;
        if (!ok || inst !== 32'h2008_0005 || inst_pc !== 32'h0040_0020 || inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL boot_inst: got=%b valid=%b inst=%h inst_pc=%h, want 1 1 20080005 00400020",
                     ok, inst_valid, inst, inst_pc);
        end
        total++;
        if (!ok || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL boot_sb: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stream();
        int          steves, cyc, n_inst, viol;
        int          sc [3];
        bit          prev_steve, prev_valid, ok;
        exp_t        e;
        logic [31:0] want_pc [3];
        want_pc[0] = 32'h0040_0020;
        want_pc[1] = 32'h0040_0024;
        want_pc[2] = 32'h0040_0028;
        mem_en = 1'b1; mem_lat = 0;
        do_reset(32'h0040_0020);
        inst_ready = 1'b1;
        steves = 0; cyc = 0; n_inst = 0; viol = 0;
        prev_steve = 1'b0; prev_valid = 1'b0;
        for (int i = 0; i < 3; i++) sc[i] = 0;
        while (steves < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (steve && (prev_steve || imem_req)) viol++;
            if (inst_valid && !prev_valid && n_inst < 3) begin
                pop_exp(ok, e);
                total++;
                if (!ok || inst_pc !== want_pc[n_inst] || {inst_pc, inst} !== e) begin
                    bad++;
                    $display("FAIL stream_inst%0d: got %h_%h, expected %h_%h (pc %h)",
                             n_inst, inst_pc, inst, e.pc, e.word, want_pc[n_inst]);
                end
                n_inst++;
            end
            if (steve) begin
                sc[steves] = cyc;
                steves++;
                if (steves == 3) inst_ready = 1'b0;
            end
            prev_steve = steve;
            prev_valid = inst_valid;
        end
        total++;
        if (steves != 3 || n_inst != 3) begin
            bad++;
            $display("FAIL stream_count: steve pulses=%0d insts=%0d, want 3 3", steves, n_inst);
        end
        total++;
        if (sc[1] - sc[0] != 3 || sc[2] - sc[1] != 3) begin
            bad++;
            $display("FAIL stream_spacing: gaps %0d %0d, want 3 3", sc[1] - sc[0], sc[2] - sc[1]);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL stream_steve_rules: violations=%0d, want 0", viol);
        end
        total++;
        if (fetch_count !== 32'd3) begin
            bad++;
            $display("FAIL stream_fetch_count: got %0d, want 3", fetch_count);
        end
        // Drain the next fetched instruction so the scoreboard stays aligned.
        next_inst(10, ok, e);
        total++;
        if (!ok || inst_pc !== 32'h0040_002C || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL stream_next: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure_branch();
        bit   ok, stable;
        exp_t e;
        int   pulses;
        mem_en = 1'b1; mem_lat = 1;
        do_reset(32'h0040_0020);
        next_inst(20, ok, e);
        total++;
        if (!ok || inst_pc !== 32'h0040_0020 || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL bp_first: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (inst !== word_for(32'h0040_0020) || inst_pc !== 32'h0040_0020 ||
                steve !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b1)
                stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold: inst=%h inst_pc=%h steve=%b req=%b valid=%b, want held instruction, no pulse/request",
                     inst, inst_pc, steve, imem_req, inst_valid);
        end
        inst_ready = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (steve) pulses++;
            inst_ready = 1'b0;
        end
        total++;
        if (pulses != 1 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0024) begin
            bad++;
            $display("FAIL bp_release: pulses=%0d req=%b addr=%h, want 1 1 00400024", pulses, imem_req, imem_addr);
        end
        next_inst(20, ok, e);
        total++;
        if (!ok || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL bp_second: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
        inst_ready = 1'b1;
        wait_steve(10, ok);
        inst_ready = 1'b0;
        next_inst(20, ok, e);
        total++;
        if (!ok || inst_pc !== 32'h0040_0028 || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL br_source: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
        // Branch taken from 0x00400028 with imm16=4: 0x28 + 4 + (4<<2) = 0x3C.
        npc_sel = 1'b1; imm16 = 16'h0004; inst_ready = 1'b1;
        wait_steve(10, ok);
        inst_ready = 1'b0;
        @(negedge clk);
        npc_sel = 1'b0;
        total++;
        if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h0040_003C) begin
            bad++;
            $display("FAIL br_target: steve=%b req=%b addr=%h, want 1 1 0040003c", ok, imem_req, imem_addr);
        end
        next_inst(20, ok, e);
        total++;
        if (!ok || inst_pc !== 32'h0040_003C || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL br_inst: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timeout();
        int n_req, cyc, early_err;
        bit done;
        mem_en = 1'b0; force_ack = 1'b0;
        do_reset(32'h0040_0300);
        n_req = 0; cyc = 0; early_err = 0; done = 1'b0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (imem_req) begin
                n_req++;
                if (err) early_err++;
            end else if (n_req > 0) begin
                done = 1'b1;
            end
        end
        total++;
        if (n_req != int'(TIMEOUT) || early_err != 0) begin
            bad++;
            $display("FAIL timeout_cycles: req high %0d cycles, early err %0d, want %0d 0", n_req, early_err, TIMEOUT);
        end
        total++;
        if (err !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flag: err=%b req=%b, want 1 0", err, imem_req);
        end
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || steve !== 1'b0 ||
            inst !== 32'h0 || fetch_count !== 32'h0) begin
            bad++;
            $display("FAIL timeout_late_ack: err=%b req=%b valid=%b steve=%b inst=%h count=%h, want 1 0 0 0 0 0",
                     err, imem_req, inst_valid, steve, inst, fetch_count);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        bit   ok;
        exp_t e;
        mem_en = 1'b0; force_ack = 1'b0;
        do_reset(32'h0040_0100);
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100 || err !== 1'b0) begin
            bad++;
            $display("FAIL arst_pre: req=%b addr=%h err=%b, want 1 00400100 0", imem_req, imem_addr, err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
            steve !== 1'b0 || err !== 1'b0 || fetch_count !== 32'h0) begin
            bad++;
            $display("FAIL arst_clear: req=%b addr=%h valid=%b steve=%b err=%b count=%h, want all 0",
                     imem_req, imem_addr, inst_valid, steve, err, fetch_count);
        end
        @(negedge clk);
        mem_en = 1'b1; mem_lat = 0;
        rd_idx = exp_q.size();
        rst_n  = 1'b1;
        next_inst(20, ok, e);
        total++;
        if (!ok || inst_pc !== 32'h0040_0100 || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL arst_refetch: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_count_wrap();
        bit   ok;
        exp_t e;
        mem_en = 1'b1; mem_lat = 0;
        do_reset(32'h0040_0200);
        next_inst(20, ok, e);
        total++;
        if (!ok || {inst_pc, inst} !== e) begin
            bad++;
            $display("FAIL wrap_fetch: got %h_%h, expected %h_%h", inst_pc, inst, e.pc, e.word);
        end
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        total++;
        if (fetch_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h, want ffffffff", fetch_count);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        wait_steve(10, ok);
        inst_ready = 1'b0;
        total++;
        if (!ok || fetch_count !== 32'h0) begin
            bad++;
            $display("FAIL wrap_count: steve=%b count=%h, want 1 00000000", ok, fetch_count);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure_branch();
        test_timeout();
        test_async_reset();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
